beat_peak_detector: RTL

- Parametrised hysteresis peak/trough detector for the filtered pulse-sensor stream. It sits between the FIR filter output and the heart-rate/display logic.
- Consumes one qualified sample per `in_valid` and confirms a peak or trough only after the signal retreats by a hysteresis margin.
- Enforces a refractory interval on peaks, counts peaks and troughs, latches extreme values, and reports the peak-to-peak interval in samples for BPM computation downstream.

---
 rtl/beat_peak_detector.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/beat_peak_detector.sv
// rtl/beat_peak_detector.sv - hysteresis peak/trough detector with refractory check and interval measurement
module beat_peak_detector #(
  parameter int DATA_W  = 10,
  parameter int CNT_W   = 10,
  parameter int INT_W   = 16,
  parameter int HYST    = 8,
  parameter int REFRACT = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [CNT_W-1:0]  num_peaks,
  output logic [CNT_W-1:0]  num_troughs,
  output logic              peak_pulse,
  output logic              trough_pulse,
  output logic              peak_rej,
  output logic [DATA_W-1:0] peak_value,
  output logic [DATA_W-1:0] trough_value,
  output logic [INT_W-1:0]  interval,
  output logic              interval_valid
);

  typedef enum logic [1:0] {INIT, RISING, FALLING} state_t;

  // Comparisons run one bit wider than the sample so x+HYST never wraps.
  localparam logic [DATA_W:0]  HYST_E    = (DATA_W+1)'(HYST);
  localparam logic [INT_W:0]   REFRACT_E = (INT_W+1)'(REFRACT);
  localparam logic [INT_W-1:0] CNT_SAT   = {INT_W{1'b1}};

  state_t             state_q, state_d;
  logic               ref_ok_q, ref_ok_d;
  logic [DATA_W-1:0]  ref_q, ref_d;
  logic [DATA_W-1:0]  run_max_q, run_max_d;
  logic [DATA_W-1:0]  run_min_q, run_min_d;
  logic [INT_W-1:0]   cnt_q, cnt_d;
  logic               have_peak_q, have_peak_d;
  logic [CNT_W-1:0]   num_peaks_d, num_troughs_d;
  logic               peak_pulse_d, trough_pulse_d, peak_rej_d, interval_valid_d;
  logic [DATA_W-1:0]  peak_value_d, trough_value_d;
  logic [INT_W-1:0]   interval_d;

  logic [DATA_W:0]    x_e;
  logic [INT_W-1:0]   cnt_next;

  assign x_e      = {1'b0, in_data};
  assign cnt_next = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + INT_W'(1);

  // Next-state and output decode; at most one extreme is confirmed per sample.
  always_comb begin
    state_d          = state_q;
    ref_ok_d         = ref_ok_q;
    ref_d            = ref_q;
    run_max_d        = run_max_q;
    run_min_d        = run_min_q;
    cnt_d            = cnt_q;
    have_peak_d      = have_peak_q;
    num_peaks_d      = num_peaks;
    num_troughs_d    = num_troughs;
    peak_value_d     = peak_value;
    trough_value_d   = trough_value;
    interval_d       = interval;
    peak_pulse_d     = 1'b0;
    trough_pulse_d   = 1'b0;
    peak_rej_d       = 1'b0;
    interval_valid_d = 1'b0;
    if (in_valid) begin
      cnt_d = cnt_next;
      case (state_q)
        INIT: begin
          if (!ref_ok_q) begin
            ref_d    = in_data;
            ref_ok_d = 1'b1;
          end else if (x_e >= {1'b0, ref_q} + HYST_E) begin
            run_max_d = in_data;
            state_d   = RISING;
          end else if (x_e + HYST_E <= {1'b0, ref_q}) begin
            run_min_d = in_data;
            state_d   = FALLING;
          end
        end
        RISING: begin
          if (in_data > run_max_q) begin
            run_max_d = in_data;
          end else if (x_e + HYST_E <= {1'b0, run_max_q}) begin
            run_min_d = in_data;
            state_d   = FALLING;
            if (!have_peak_q || ({1'b0, cnt_next} >= REFRACT_E)) begin
              if (have_peak_q) begin
                interval_d       = cnt_next;
                interval_valid_d = 1'b1;
              end
              have_peak_d  = 1'b1;
              cnt_d        = '0;
              peak_pulse_d = 1'b1;
              num_peaks_d  = num_peaks + CNT_W'(1);
              peak_value_d = run_max_q;
            end else begin
              peak_rej_d = 1'b1;
            end
          end
        end
        FALLING: begin
          if (in_data < run_min_q) begin
            run_min_d = in_data;
          end else if (x_e >= {1'b0, run_min_q} + HYST_E) begin
            trough_pulse_d = 1'b1;
            num_troughs_d  = num_troughs + CNT_W'(1);
            trough_value_d = run_min_q;
            run_max_d      = in_data;
            state_d        = RISING;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  // State and output registers; async reset, soft clear has priority over samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      state_q        <= INIT;
      ref_ok_q       <= 1'b0;
      ref_q          <= '0;
      run_max_q      <= '0;
      run_min_q      <= '0;
      cnt_q          <= '0;
      have_peak_q    <= 1'b0;
      num_peaks      <= '0;
      num_troughs    <= '0;
      peak_pulse     <= 1'b0;
      trough_pulse   <= 1'b0;
      peak_rej       <= 1'b0;
      peak_value     <= '0;
      trough_value   <= '0;
      interval       <= '0;
      interval_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_ok_q       <= ref_ok_d;
      ref_q          <= ref_d;
      run_max_q      <= run_max_d;
      run_min_q      <= run_min_d;
      cnt_q          <= cnt_d;
      have_peak_q    <= have_peak_d;
      num_peaks      <= num_peaks_d;
      num_troughs    <= num_troughs_d;
      peak_pulse     <= peak_pulse_d;
      trough_pulse   <= trough_pulse_d;
      peak_rej       <= peak_rej_d;
      peak_value     <= peak_value_d;
      trough_value   <= trough_value_d;
      interval       <= interval_d;
      interval_valid <= interval_valid_d;
    end
  end

endmodule
